// File: rtl/bit_decode.sv
// bit_decode: two-entry ping-pong buffer turning accepted bit indices into one-hot words.
// Defining BITPOS_STATS_EN adds a 16-bit xfer_cnt output counting completed sink transfers.
module bit_decode #(
    parameter int DATA_WIDTH = 8,
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_src,
    input  logic [IW-1:0]         index_in,
    output logic                  rdy_src,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  vld_sink,
    input  logic                  rdy_sink
`ifdef BITPOS_STATS_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);

    // Out-of-range indices (non power-of-two widths) match no bit and decode to zero.
    function automatic logic [DATA_WIDTH-1:0] decode_onehot(input logic [IW-1:0] idx);
        logic [DATA_WIDTH-1:0] word;
        word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            word[i] = (idx == IW'(i));
        end
        return word;
    endfunction

    logic [1:0]          valid_q, valid_d;
    logic [1:0][IW-1:0]  idx_q, idx_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic                rdy_src_q, rdy_src_d;
    logic                vld_sink_q, vld_sink_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                src_xfer_s;
    logic                snk_xfer_s;

    assign src_xfer_s = vld_src & rdy_src_q;
    assign snk_xfer_s = valid_q[rd_ptr_q] & rdy_sink;

    // Next state of the store; outputs are precomputed here so they leave the block registered.
    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (snk_xfer_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (src_xfer_s) begin
            valid_d[wr_ptr_q] = 1'b1;
            idx_d[wr_ptr_q]   = index_in;
            wr_ptr_d          = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        rdy_src_d  = ~(valid_d[0] & valid_d[1]);
        vld_sink_d = valid_d[rd_ptr_d];
        if (vld_sink_d) begin
            data_out_d = decode_onehot(idx_d[rd_ptr_d]);
        end else begin
            data_out_d = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= 2'b00;
            idx_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rdy_src_q  <= 1'b0;
            vld_sink_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rdy_src_q  <= rdy_src_d;
            vld_sink_q <= vld_sink_d;
            data_out_q <= data_out_d;
        end
    end

    assign rdy_src  = rdy_src_q;
    assign vld_sink = vld_sink_q;
    assign data_out = data_out_q;

`ifdef BITPOS_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Completed sink transfers, wrapping naturally at 16 bits.
    always_comb begin
        if (snk_xfer_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bit_decode.sv
// Self-checking bench for bit_decode: directed scenarios plus a negedge scoreboard monitor.
module tb_bit_decode;

    logic       clk;
    logic       rst;
    logic       vld_src;
    logic [2:0] index_in;
    logic       rdy_src;
    logic [7:0] data_out;
    logic       vld_sink;
    logic       rdy_sink;
`ifdef BITPOS_STATS_EN
    logic [15:0] xfer_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sb_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] hold_data  = 8'h00;

    bit_decode #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .vld_src  (vld_src),
        .index_in (index_in),
        .rdy_src  (rdy_src),
        .data_out (data_out),
        .vld_sink (vld_sink),
        .rdy_sink (rdy_sink)
`ifdef BITPOS_STATS_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on source transfer, pop and compare on sink transfer, check stall stability.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!rst) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_vec++;
                if (vld_sink !== 1'b1 || data_out !== hold_data) begin
                    n_err++;
                    $display("FAIL stall_stable: got vld=%b data=%h, want vld=1 data=%h", vld_sink, data_out, hold_data);
                end
            end
            n_vec++;
            if (vld_sink === 1'b1 && !$onehot(data_out)) begin
                n_err++;
                $display("FAIL onehot: data=%h with vld_sink=1", data_out);
            end else if (vld_sink !== 1'b1 && data_out !== 8'h00) begin
                n_err++;
                $display("FAIL idle_zero: data=%h with vld_sink=%b, want 00", data_out, vld_sink);
            end
            if (vld_sink === 1'b1 && rdy_sink === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: got data=%h, want nothing", data_out);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (data_out !== exp_w) begin
                        n_err++;
                        $display("FAIL sb_data: got %h, want %h", data_out, exp_w);
                    end
                end
            end
            if (vld_src === 1'b1 && rdy_src === 1'b1) begin
                exp_w = 8'h01 << index_in;
                sb_q.push_back(exp_w);
            end
            stall_prev = vld_sink && !rdy_sink;
            hold_data  = data_out;
        end
    end

    task automatic test_reset();
        rst = 1'b0; vld_src = 1'b0; rdy_sink = 1'b0; index_in = 3'd0;
        repeat (3) step();
        n_vec++;
        if (rdy_src !== 1'b0 || vld_sink !== 1'b0 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h, want 0 0 00", rdy_src, vld_sink, data_out);
        end
        rst = 1'b1;
        step();
        n_vec++;
        if (rdy_src !== 1'b1 || vld_sink !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", rdy_src, vld_sink);
        end
    endtask

    task automatic test_single();
        rdy_sink = 1'b1; vld_src = 1'b1; index_in = 3'd3;
        step();
        vld_src = 1'b0;
        n_vec++;
        if (vld_sink !== 1'b1 || data_out !== 8'h08 || rdy_src !== 1'b1) begin
            n_err++;
            $display("FAIL single: vld=%b data=%h rdy=%b, want 1 08 1", vld_sink, data_out, rdy_src);
        end
        step();
        n_vec++;
        if (vld_sink !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: vld=%b, want 0", vld_sink);
        end
    endtask

    task automatic test_backpressure();
        rdy_sink = 1'b0; vld_src = 1'b1; index_in = 3'd5;
        step();
        index_in = 3'd1;
        step();
        n_vec++;
        if (rdy_src !== 1'b0 || data_out !== 8'h20) begin
            n_err++;
            $display("FAIL bp_full: rdy=%b data=%h, want 0 20", rdy_src, data_out);
        end
        index_in = 3'd7;
        step();
        vld_src = 1'b0;
        n_vec++;
        if (rdy_src !== 1'b0 || data_out !== 8'h20) begin
            n_err++;
            $display("FAIL bp_ignore: rdy=%b data=%h, want 0 20", rdy_src, data_out);
        end
        rdy_sink = 1'b1;
        step();
        n_vec++;
        if (data_out !== 8'h02 || rdy_src !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: data=%h rdy=%b, want 02 1", data_out, rdy_src);
        end
        step();
        n_vec++;
        if (vld_sink !== 1'b0 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL bp_empty: vld=%b data=%h, want 0 00", vld_sink, data_out);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp_w;
        rdy_sink = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vld_src  = 1'b1;
            index_in = 3'(i);
            step();
            exp_w = 8'h01 << i;
            n_vec++;
            if (vld_sink !== 1'b1 || data_out !== exp_w || rdy_src !== 1'b1) begin
                n_err++;
                $display("FAIL stream[%0d]: vld=%b data=%h rdy=%b, want 1 %h 1", i, vld_sink, data_out, rdy_src, exp_w);
            end
        end
        vld_src = 1'b0;
        step();
        n_vec++;
        if (vld_sink !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: vld=%b, want 0", vld_sink);
        end
    endtask

    task automatic test_mid_reset();
        rdy_sink = 1'b0; vld_src = 1'b1; index_in = 3'd2;
        step();
        index_in = 3'd6;
        step();
        vld_src = 1'b0;
        rst = 1'b0;
        step();
        n_vec++;
        if (vld_sink !== 1'b0 || data_out !== 8'h00 || rdy_src !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: vld=%b data=%h rdy=%b, want 0 00 0", vld_sink, data_out, rdy_src);
        end
        rst = 1'b1;
        rdy_sink = 1'b1;
        step();
        n_vec++;
        if (rdy_src !== 1'b1 || vld_sink !== 1'b0 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL mid_release: rdy=%b vld=%b data=%h, want 1 0 00", rdy_src, vld_sink, data_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            vld_src  = 1'($urandom_range(0, 1));
            rdy_sink = 1'($urandom_range(0, 1));
            index_in = 3'($urandom_range(0, 7));
            step();
        end
        vld_src  = 1'b0;
        rdy_sink = 1'b1;
        repeat (4) step();
        n_vec++;
        if (sb_q.size() != 0 || vld_sink !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain: %0d pending, vld=%b, want 0 0", sb_q.size(), vld_sink);
        end
    endtask

`ifdef BITPOS_STATS_EN
    task automatic test_counter();
        rst = 1'b0; vld_src = 1'b0; rdy_sink = 1'b1;
        step();
        rst = 1'b1;
        step();
        n_vec++;
        if (xfer_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL cnt_reset: got %h, want 0000", xfer_cnt);
        end
        vld_src = 1'b1;
        for (int c = 0; c < 65534; c++) begin
            index_in = 3'(c);
            step();
        end
        vld_src = 1'b0;
        repeat (2) step();
        n_vec++;
        if (xfer_cnt !== 16'hFFFE) begin
            n_err++;
            $display("FAIL cnt_preload: got %h, want fffe", xfer_cnt);
        end
        vld_src = 1'b1;
        repeat (2) step();
        vld_src = 1'b0;
        repeat (2) step();
        n_vec++;
        if (xfer_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL cnt_wrap: got %h, want 0000", xfer_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; vld_src = 1'b0; rdy_sink = 1'b0; index_in = 3'd0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_mid_reset();
        test_random();
`ifdef BITPOS_STATS_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
